// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// master drives operations and MTHI/MTLO writes; slave returns status and the HI/LO registers.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mt_hi, mt_lo, write_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, mt_hi, mt_lo, write_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO: WIDTH CALC cycles plus one FIXUP cycle.
// Start, MTHI and MTLO are accepted only while idle; anything presented while busy is dropped.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  mult_div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               b_zero_q, b_zero_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic idle, calc_en, load_res;
  logic start_acc, mt_acc;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST_CNT) state_d = S_FIXUP;
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    idle     = (state_q == S_IDLE);
    calc_en  = (state_q == S_CALC);
    load_res = (state_q == S_FIXUP);
  end

  assign start_acc = idle & bus.start;
  assign mt_acc    = idle & ~bus.start;

  // Operand conditioning: signed ops work on magnitudes, signs are restored in FIXUP.
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.a[WIDTH-1];
    b_neg     = op_signed & bus.b[WIDTH-1];
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
  end

  // One multiply step: conditional add of the multiplicand, then shift the product right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  // One restoring divide step: shift left, trial-subtract the divisor, keep on non-negative.
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    div_step = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                               : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
  end

  // Sign fixup and HI/LO mapping of the finished accumulator.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!op_q[1]) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_zero_q) begin
      res_hi = a_raw_q;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    a_raw_d   = a_raw_q;
    b_zero_d  = b_zero_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (start_acc) begin
      cnt_d     = '0;
      op_d      = bus.op;
      a_raw_d   = bus.a;
      b_zero_d  = (bus.b == '0);
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      opnd_d    = bus.op[1] ? b_mag : a_mag;
      acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
    end else if (calc_en) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = op_q[1] ? div_step : mul_step;
    end

    if (load_res) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (mt_acc) begin
      if (bus.mt_hi) hi_d = bus.write_data;
      if (bus.mt_lo) lo_d = bus.write_data;
    end

    done_d = load_res;
    dbz_d  = load_res & op_q[1] & b_zero_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      a_raw_q   <= '0;
      b_zero_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      a_raw_q   <= a_raw_d;
      b_zero_q  <= b_zero_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = ~idle;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operations against an arithmetic model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_div_unit_if #(.WIDTH(W)) bus();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    logic [31:0]     q, r;
    case (op)
      2'd0: begin
        sa = $signed(a); sb = $signed(b); sp = sa * sb;
        return {1'b0, sp[63:0]};
      end
      2'd1: begin
        ua = a; ub = b; up = ua * ub;
        return {1'b0, up[63:0]};
      end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        ia = $signed(a); ib = $signed(b);
        q = ia / ib; r = ia % ib;
        return {1'b0, r, q};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = a / b; r = a % b;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Issues one operation and follows it to Done. inj>0 pulses a rogue Start+MtHi at that busy cycle;
  // mt_with_start presents MtLo together with the accepted Start.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input bit mt_with_start,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat, output int busy_cnt, output bit stable);
    logic [31:0] h0, l0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (mt_with_start) begin
      bus.mt_lo = 1'b1; bus.write_data = 32'h1111_1111;
    end
    h0 = bus.hi; l0 = bus.lo;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mt_lo = 1'b0;
    if (mt_with_start) l0 = bus.lo;
    lat = 0; busy_cnt = int'(bus.busy); stable = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == inj) begin
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd2;
        bus.mt_hi = 1'b1; bus.write_data = 32'h0000_AAAA;
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mt_hi = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
      busy_cnt += int'(bus.busy);
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
    end
    hi = bus.hi; lo = bus.lo; dbz = bus.div_by_zero;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj, input bit mt_with_start, input bit full);
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat, bc;
    bit          st;
    logic [64:0] exp;
    exp = model(op, a, b);
    run_op(op, a, b, inj, mt_with_start, hi, lo, dbz, lat, bc, st);
    check({tag, ".hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, ".lo"}, 64'(lo), 64'(exp[31:0]));
    check({tag, ".dbz"}, 64'(dbz), 64'(exp[64]));
    check({tag, ".lat"}, 64'(lat), 64'd33);
    if (full) begin
      check({tag, ".busy_cycles"}, 64'(bc), 64'd33);
      check({tag, ".hilo_hold"}, 64'(st), 64'd1);
    end
  endtask

  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;
  bit          seen_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0; bus.write_data = '0;

    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.dbz",  64'(bus.div_by_zero), 64'd0);
    check("rst.hi",   64'(bus.hi), 64'd0);
    check("rst.lo",   64'(bus.lo), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // MTHI + MTLO while idle
    @(negedge clk);
    bus.mt_hi = 1'b1; bus.mt_lo = 1'b1; bus.write_data = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.mt_hi = 1'b0; bus.mt_lo = 1'b0;
    check("mt.hi", 64'(bus.hi), 64'h5A5A_5A5A);
    check("mt.lo", 64'(bus.lo), 64'h5A5A_5A5A);

    // Reset in the middle of CALC
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd7; bus.b = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen_done |= bus.done;
    end
    rst = 1'b1;
    #1;
    check("midrst.busy", 64'(bus.busy), 64'd0);
    check("midrst.hi",   64'(bus.hi), 64'd0);
    check("midrst.lo",   64'(bus.lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= bus.done;
    end
    check("midrst.no_done", 64'(seen_done), 64'd0);
    do_op("midrst.mulu3x4", 2'd1, 32'd3, 32'd4, 0, 1'b0, 1'b1);

    // Directed arithmetic corners
    do_op("mult.neg2x3", 2'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 1'b1);
    do_op("multu.max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    do_op("div.m7d2",    2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    do_op("div.ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    do_op("divu.100d7",  2'd3, 32'd100, 32'd7, 0, 1'b0, 1'b0);
    do_op("div.7dm2",    2'd2, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, 1'b0);
    do_op("div.zero",    2'd2, 32'hFFFF_FF00, 32'd0, 0, 1'b0, 1'b0);
    do_op("divu.zero",   2'd3, 32'h0000_1234, 32'd0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("divu.zero.done_1cyc", 64'(bus.done), 64'd0);
    check("divu.zero.dbz_1cyc",  64'(bus.div_by_zero), 64'd0);

    // Start and MtHi while busy must be ignored
    do_op("busy_ignore", 2'd3, 32'd100, 32'd7, 5, 1'b0, 1'b1);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= bus.done;
    end
    check("busy_ignore.no_second_done", 64'(seen_done), 64'd0);
    check("busy_ignore.idle", 64'(bus.busy), 64'd0);

    // Start together with MtLo: the operation wins
    do_op("start_mt", 2'd1, 32'd6, 32'd7, 0, 1'b1, 1'b1);

    // MTHI alone leaves LO untouched
    @(negedge clk);
    bus.mt_hi = 1'b1; bus.write_data = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.mt_hi = 1'b0;
    check("mthi_only.hi", 64'(bus.hi), 64'hCAFE_0001);
    check("mthi_only.lo", 64'(bus.lo), 64'd42);

    // Random operations, issued back to back
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       r_a = $urandom_range(0, 50);
        1:       r_a = -32'($urandom_range(1, 50));
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = -32'($urandom_range(1, 9));
        2:       r_b = $urandom_range(1, 9);
        default: r_b = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), r_op, r_a, r_b, 0, 1'b0, (i % 8) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
